// File: rtl/riscv_mult_pkg.sv
// Shared types for the iterative multiplier/MAC: operation select, signedness bit positions,
// and sequencer states.
package riscv_mult_pkg;

  // Result selection; encoding 3 is reserved and folded onto MulLo at accept time.
  typedef enum logic [1:0] {
    MulLo  = 2'd0,
    MulHi  = 2'd1,
    MulMac = 2'd2
  } mul_op_e;

  // Bit positions inside signed_i.
  localparam int unsigned SignA = 0;
  localparam int unsigned SignB = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mult_state_e;

endpackage

// File: rtl/riscv_mult_slice.sv
// Combinational (XLEN+1)x(SLICE_W+1) signed partial product. The caller supplies the extension
// bit of each operand, so the same multiplier serves signed and unsigned operands.
module riscv_mult_slice #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SLICE_W = 16
) (
  input  logic [XLEN-1:0]           a_i,
  input  logic                      a_signed_i,
  input  logic [SLICE_W-1:0]        b_i,
  input  logic                      b_ext_i,
  output logic [XLEN+SLICE_W+1:0]   pp_o
);

  localparam int unsigned PW = XLEN + SLICE_W + 2;

  logic          a_top;
  logic [PW-1:0] a_x;
  logic [PW-1:0] b_x;

  // Sign-extend both operands to the full product width; the truncated product is then exact.
  always_comb begin
    a_top = a_signed_i & a_i[XLEN-1];
    a_x   = {{(SLICE_W + 2){a_top}}, a_i};
    b_x   = {{(XLEN + 2){b_ext_i}}, b_i};
    pp_o  = a_x * b_x;
  end

endmodule

// File: rtl/riscv_mult_seq.sv
// Iterative integer multiplier/MAC for the EX stage. Consumes SLICE_W bits of op_b per cycle,
// accumulating with a shift-add so only one narrow signed multiplier is needed.
module riscv_mult_seq
  import riscv_mult_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SLICE_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic [1:0]      signed_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [XLEN-1:0] op_c_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned NSTEP = XLEN / SLICE_W;
  localparam int unsigned CntW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int unsigned PW    = XLEN + SLICE_W + 2;
  // Running upper partial sum; two spare bits keep the signed sum exact for every combo.
  localparam int unsigned HW    = XLEN + 2;

  if (((SLICE_W != 8) && (SLICE_W != 16) && (SLICE_W != 32)) || ((XLEN % SLICE_W) != 0))
  begin : gen_param_check
    $fatal(1, "riscv_mult_seq: SLICE_W must be 8, 16 or 32 and divide XLEN");
  end

  mult_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_sh_q, b_sh_d;
  logic [XLEN-1:0]   c_q, c_d;
  mul_op_e           op_q, op_d;
  logic [1:0]        sgn_q, sgn_d;
  logic [HW-1:0]     acc_hi_q, acc_hi_d;
  logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept;
  logic              last_step;
  logic              b_ext;
  logic [PW-1:0]     pp;
  logic [PW-1:0]     step_sum;
  logic [HW-1:0]     step_hi;
  logic [XLEN-1:0]   step_lo;

  // Handshake: ready depends on ready_i (never valid_i); a flush blocks any same-cycle accept.
  always_comb begin
    ready_o = (state_q == StIdle) | ((state_q == StDone) & ready_i);
    accept  = valid_i & ready_o & ~flush_i;
    valid_o = (state_q == StDone);
    busy_o  = (state_q != StIdle);
    result_o = result_q;
  end

  // Only the final slice of a signed op_b carries a sign; lower slices are plain magnitudes.
  always_comb begin
    last_step = (cnt_q == CntW'(NSTEP - 1));
    b_ext     = last_step & sgn_q[SignB] & b_sh_q[SLICE_W-1];
  end

  riscv_mult_slice #(
    .XLEN    (XLEN),
    .SLICE_W (SLICE_W)
  ) u_slice (
    .a_i        (a_q),
    .a_signed_i (sgn_q[SignA]),
    .b_i        (b_sh_q[SLICE_W-1:0]),
    .b_ext_i    (b_ext),
    .pp_o       (pp)
  );

  // Shift-add step: add pp to the signed upper part, retire SLICE_W low bits into acc_lo.
  always_comb begin
    step_sum = {{SLICE_W{acc_hi_q[HW-1]}}, acc_hi_q} + pp;
    step_hi  = step_sum[PW-1:SLICE_W];
    step_lo  = XLEN'({step_sum[SLICE_W-1:0], acc_lo_q} >> SLICE_W);
  end

  // Next-state logic: FSM sequencing, operand capture and final result formation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_sh_d   = b_sh_q;
    c_d      = c_q;
    op_d     = op_q;
    sgn_d    = sgn_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: ;
      StBusy: begin
        if (flush_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          b_sh_d   = b_sh_q >> SLICE_W;
          cnt_d    = cnt_q + CntW'(1);
          if (last_step) begin
            state_d = StDone;
            cnt_d   = '0;
            unique case (op_q)
              MulHi:   result_d = step_hi[XLEN-1:0];
              MulMac:  result_d = step_lo + c_q;
              default: result_d = step_lo;
            endcase
          end
        end
      end
      StDone: begin
        if (flush_i || ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Accept overrides the DONE->IDLE return, giving back-to-back issue with no bubble.
    if (accept) begin
      state_d  = StBusy;
      cnt_d    = '0;
      a_d      = op_a_i;
      b_sh_d   = op_b_i;
      c_d      = op_c_i;
      op_d     = (op_i == 2'd3) ? MulLo : mul_op_e'(op_i);
      sgn_d    = signed_i;
      acc_hi_d = '0;
      acc_lo_d = '0;
    end
  end

  // State and datapath registers; async reset returns everything to idle with a zero result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_sh_q   <= '0;
      c_q      <= '0;
      op_q     <= MulLo;
      sgn_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_sh_q   <= b_sh_d;
      c_q      <= c_d;
      op_q     <= op_d;
      sgn_q    <= sgn_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      result_q <= result_d;
    end
  end

endmodule
